run_ctrl: RTL and testbench

Batch run controller that sits between the host/testbench side and the `TopLevel` processor. It owns the processor's `Reset`/`Start`/`Ack` handshake and arbitrates the single data-memory port between host preload/readback and the running core. It also counts run cycles and aborts runaway programs on a timeout.

---
 rtl/run_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_run_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//
// Batch run controller for the TopLevel processor. It owns the core's
// Reset/Start/Ack handshake, arbitrates the single data-memory port between
// the host and the running core, counts run cycles and aborts runaway programs
// once a programmable cycle limit is reached.
//
// Ports
//   Clk, Reset_n          system clock, asynchronous active-low reset
//   Go                    host launch request (rising edge acts)
//   TimeoutLimit          max RUN cycles, 0 disables the timeout
//   HostWrEn/Addr/WrData  host memory port;  HostRdData back to host
//   HostGrant             host currently owns the data-memory port
//   CoreReset/CoreStart   drive TopLevel.Reset / TopLevel.Start
//   CoreAck               TopLevel.Ack done flag
//   CoreWrEn/Addr/WrData  core memory port;  CoreRdData back to core
//   DmWrEn/Addr/WrData    to data memory;    DmRdData from data memory
//   Busy/Done/TimedOut    run status
//   CycleCount            RUN cycles of the current or last run
// -----------------------------------------------------------------------------
module run_ctrl #(
    parameter int RST_CYC   = 2,
    parameter int START_CYC = 1,
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int CW        = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Go,
    input  logic [CW-1:0] TimeoutLimit,
    input  logic          HostWrEn,
    input  logic [AW-1:0] HostAddr,
    input  logic [DW-1:0] HostWrData,
    output logic [DW-1:0] HostRdData,
    output logic          HostGrant,
    output logic          CoreReset,
    output logic          CoreStart,
    input  logic          CoreAck,
    input  logic          CoreWrEn,
    input  logic [AW-1:0] CoreAddr,
    input  logic [DW-1:0] CoreWrData,
    output logic [DW-1:0] CoreRdData,
    output logic          DmWrEn,
    output logic [AW-1:0] DmAddr,
    output logic [DW-1:0] DmWrData,
    input  logic [DW-1:0] DmRdData,
    output logic          Busy,
    output logic          Done,
    output logic          TimedOut,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_START,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_e;

    // Phase counter is shared by RST and START, so size it for the longer one.
    localparam int PMAX = (RST_CYC > START_CYC) ? RST_CYC : START_CYC;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [PW-1:0] RST_LAST   = PW'(RST_CYC - 1);
    localparam logic [PW-1:0] START_LAST = PW'(START_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          go_q;
    logic          go_rise;
    logic          host_own;

    assign go_rise = Go & ~go_q;

    // -------------------------------------------------------------------------
    // State, phase, cycle counter and Go edge-detect registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            go_q    <= Go;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                // Launch from any resting state; a fresh run starts its count at 0.
                if (go_rise) begin
                    state_d = S_RST;
                    phase_d = '0;
                    cnt_d   = '0;
                end
            end
            S_RST: begin
                if (phase_q == RST_LAST) begin
                    state_d = S_START;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_START: begin
                if (phase_q == START_LAST) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            S_RUN: begin
                // Ack is checked first so it wins when it lands on the limit.
                // The count is frozen on the exit edge, leaving the value that
                // was compared against the limit visible in DONE/TIMEOUT.
                if (CoreAck) begin
                    state_d = S_DONE;
                end else if ((TimeoutLimit != '0) && (cnt_q == TimeoutLimit)) begin
                    state_d = S_TIMEOUT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Status and handshake outputs (decoded from state only)
    // -------------------------------------------------------------------------
    always_comb begin
        host_own  = 1'b1;
        CoreReset = 1'b1;
        CoreStart = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        TimedOut  = 1'b0;
        case (state_q)
            S_RST: begin
                Busy = 1'b1;
            end
            S_START: begin
                host_own  = 1'b0;
                CoreReset = 1'b0;
                CoreStart = 1'b1;
                Busy      = 1'b1;
            end
            S_RUN: begin
                host_own  = 1'b0;
                CoreReset = 1'b0;
                Busy      = 1'b1;
            end
            S_DONE:    Done     = 1'b1;
            S_TIMEOUT: TimedOut = 1'b1;
            default: ;
        endcase
    end

    assign HostGrant  = host_own;
    assign CycleCount = cnt_q;

    // -------------------------------------------------------------------------
    // Data-memory arbitration: pure mux, zero added latency. The non-owner
    // cannot write and sees zero read data, so a host write during a run is
    // silently dropped.
    // -------------------------------------------------------------------------
    assign DmWrEn     = host_own ? HostWrEn   : CoreWrEn;
    assign DmAddr     = host_own ? HostAddr   : CoreAddr;
    assign DmWrData   = host_own ? HostWrData : CoreWrData;
    assign HostRdData = host_own ? DmRdData   : '0;
    assign CoreRdData = host_own ? '0         : DmRdData;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

    localparam int RST_CYC   = 2;
    localparam int START_CYC = 1;
    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int CW        = 16;
    // Launch-relative period index of the first RUN cycle (period 1 follows
    // the edge that sampled go_rise).
    localparam int RUN_K     = RST_CYC + START_CYC + 1;

    logic          Clk;
    logic          Reset_n;
    logic          Go;
    logic [CW-1:0] TimeoutLimit;
    logic          HostWrEn;
    logic [AW-1:0] HostAddr;
    logic [DW-1:0] HostWrData;
    logic [DW-1:0] HostRdData;
    logic          HostGrant;
    logic          CoreReset;
    logic          CoreStart;
    logic          CoreAck;
    logic          CoreWrEn;
    logic [AW-1:0] CoreAddr;
    logic [DW-1:0] CoreWrData;
    logic [DW-1:0] CoreRdData;
    logic          DmWrEn;
    logic [AW-1:0] DmAddr;
    logic [DW-1:0] DmWrData;
    logic [DW-1:0] DmRdData;
    logic          Busy;
    logic          Done;
    logic          TimedOut;
    logic [CW-1:0] CycleCount;

    run_ctrl #(
        .RST_CYC(RST_CYC), .START_CYC(START_CYC), .AW(AW), .DW(DW), .CW(CW)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Go(Go), .TimeoutLimit(TimeoutLimit),
        .HostWrEn(HostWrEn), .HostAddr(HostAddr), .HostWrData(HostWrData),
        .HostRdData(HostRdData), .HostGrant(HostGrant),
        .CoreReset(CoreReset), .CoreStart(CoreStart), .CoreAck(CoreAck),
        .CoreWrEn(CoreWrEn), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
        .CoreRdData(CoreRdData),
        .DmWrEn(DmWrEn), .DmAddr(DmAddr), .DmWrData(DmWrData), .DmRdData(DmRdData),
        .Busy(Busy), .Done(Done), .TimedOut(TimedOut), .CycleCount(CycleCount)
    );

    // Data memory: synchronous write, combinational read.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] exp_mem [0:255];

    always @(posedge Clk) if (DmWrEn) mem[DmAddr] <= DmWrData;
    assign DmRdData = mem[DmAddr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [5:0] sts;
    assign sts = {Busy, Done, TimedOut, CoreReset, CoreStart, HostGrant};

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic hw(input int a, input logic [7:0] d);
        @(negedge Clk);
        HostWrEn = 1'b1; HostAddr = 8'(a); HostWrData = d;
        exp_mem[a] = d;
        @(negedge Clk);
        HostWrEn = 1'b0;
    endtask

    task automatic hr(input string tag, input int a);
        HostWrEn = 1'b0; HostAddr = 8'(a);
        #1;
        chk(tag, {24'b0, HostRdData}, {24'b0, exp_mem[a]});
    endtask

    // One launch. Expected behaviour comes from the launch timeline:
    // RST periods, START periods, then RUN index r = 0.. ; the run ends at the
    // first r where the core acks (r == d) or the limit is hit (r == lim),
    // ack winning a tie; the count shown is that r.
    task automatic do_run(input int d, input int lim, input bit stale,
                          input bit arb, input int abort_r);
        bit         to;
        int         e;
        int         r;
        logic [5:0] xs;
        int         xc;
        logic [7:0] v7, v5, v30;
        to = (lim != 0) && (lim < d);
        e  = to ? lim : d;
        @(negedge Clk);
        TimeoutLimit = 16'(lim);
        Go = 1'b1;
        v7 = 8'($urandom);
        HostWrEn = 1'b1; HostAddr = 8'd7; HostWrData = v7;
        exp_mem[7] = v7;   // host still owns the port in the go_rise cycle
        CoreAck = stale;
        CoreWrEn = 1'b0;
        for (int k = 1; k <= RUN_K + e + 1; k++) begin
            @(negedge Clk);
            if (k == 1) begin Go = 1'b0; HostWrEn = 1'b0; end
            r = k - RUN_K;
            if (k <= RST_CYC)      begin xs = 6'b100101; xc = 0; end
            else if (k < RUN_K)    begin xs = 6'b100010; xc = 0; end
            else if (r <= e)       begin xs = 6'b100000; xc = r; end
            else                   begin xs = {1'b0, !to, to, 3'b101}; xc = e; end
            chk("status", {26'b0, sts}, {26'b0, xs});
            chk("count", {16'b0, CycleCount}, 32'(xc));
            if (r == abort_r) begin
                #2 Reset_n = 1'b0;
                #1;
                chk("rst_status", {26'b0, sts}, 32'h05);
                chk("rst_count", {16'b0, CycleCount}, 32'd0);
                @(negedge Clk);
                Reset_n = 1'b1;
                CoreAck = 1'b0;
                return;
            end
            CoreAck = (k < RUN_K) ? stale : (r >= d);
            if (e >= 3 && r == 1) Go = 1'b1;   // ignored mid-run
            if (e >= 3 && r == 2) Go = 1'b0;
            if (arb && e >= 3 && r == 2) begin
                v5 = 8'($urandom); v30 = 8'($urandom);
                HostWrEn = 1'b1; HostAddr = 8'd5; HostWrData = v5;
                CoreWrEn = 1'b1; CoreAddr = 8'd30; CoreWrData = v30;
                exp_mem[30] = v30;
                #1;
                chk("arb_wren", {31'b0, DmWrEn}, 32'd1);
                chk("arb_addr", {24'b0, DmAddr}, 32'd30);
                chk("arb_hostrd", {24'b0, HostRdData}, 32'd0);
            end
            if (arb && e >= 3 && r == 3) begin
                HostWrEn = 1'b0; CoreWrEn = 1'b0;
            end
        end
        hr("rd7", 7);
        if (arb) begin
            hr("rd5", 5);
            hr("rd30", 30);
        end
    endtask

    initial begin
        Reset_n = 1'b0; Go = 1'b0; TimeoutLimit = '0;
        HostWrEn = 1'b0; HostAddr = '0; HostWrData = '0;
        CoreAck = 1'b0; CoreWrEn = 1'b0; CoreAddr = '0; CoreWrData = '0;
        #12;
        chk("reset_status", {26'b0, sts}, 32'h05);
        chk("reset_count", {16'b0, CycleCount}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // Preload and readback
        hw(0, 8'b10011010);
        hw(1, 8'b00000011);
        hw(5, 8'h55);
        hw(30, 8'h11);
        hw(7, 8'h00);
        hr("pre0", 0);
        hr("pre1", 1);
        chk("pre_busy", {31'b0, Busy}, 32'd0);

        // Normal run with arbitration traffic
        do_run(37, 0, 1'b0, 1'b1, -1000);

        // Timeout, then the core port is locked out
        do_run(1000, 10, 1'b0, 1'b0, -1000);
        CoreWrEn = 1'b1; CoreAddr = 8'd30; CoreWrData = ~exp_mem[30];
        #1;
        chk("lock_wren", {31'b0, DmWrEn}, 32'd0);
        chk("lock_corerd", {24'b0, CoreRdData}, 32'd0);
        @(negedge Clk);
        CoreWrEn = 1'b0;
        hr("lock_rd30", 30);

        // Ack coinciding with the limit, stale ack held through RST/START
        do_run(12, 12, 1'b1, 1'b0, -1000);

        // Randomized runs
        for (int i = 0; i < 12; i++) begin
            int d, lim;
            d   = int'($urandom_range(1, 50));
            lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 50));
            do_run(d, lim, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1000);
        end

        // Reset mid-run, then a normal relaunch
        do_run(20, 0, 1'b0, 1'b0, 5);
        do_run(6, 0, 1'b0, 1'b1, -1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
